// File: rtl/updn_counter_param_if.sv
// Control and status bundle for the parametrised up/down counter.
// The master drives the controls. The slave (the counter) drives the status.
interface updn_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              ld_cnt_;
  logic              count_enb;
  logic              updn_cnt;
  logic              sat_mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  lim_lo;
  logic [WIDTH-1:0]  lim_hi;
  logic [WIDTH-1:0]  data_in;
  logic              clr_flags;
  logic [WIDTH-1:0]  data_out;
  logic              tc;
  logic              ovf;
  logic              udf;
  logic              cfg_err;

  modport master (
    output ld_cnt_, count_enb, updn_cnt, sat_mode, step, lim_lo, lim_hi,
           data_in, clr_flags,
    input  data_out, tc, ovf, udf, cfg_err
  );

  modport slave (
    input  ld_cnt_, count_enb, updn_cnt, sat_mode, step, lim_lo, lim_hi,
           data_in, clr_flags,
    output data_out, tc, ovf, udf, cfg_err
  );
endinterface

// File: rtl/updn_counter_param.sv
// Bounded up/down counter with a programmable step and programmable limits.
// At a limit it either wraps to the opposite limit or saturates.
// It raises a terminal-count pulse and sticky overflow/underflow flags.
module updn_counter_param #(
  parameter int                 WIDTH     = 8,
  parameter int                 STEP_W    = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  updn_counter_param_if.slave   bus
);

  // All limit arithmetic is one bit wider so that neither sums nor
  // differences can alias modulo 2^WIDTH.
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] dn_diff;
  logic           up_cross;
  logic           dn_cross;
  logic           count_ok;

  // Inverted limits are flagged immediately, without waiting for a clock.
  assign bus.cfg_err = (bus.lim_lo > bus.lim_hi);

  // Next-value candidates and crossing detection for both directions.
  always_comb begin
    step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
    up_sum   = {1'b0, bus.data_out} + step_ext;
    dn_diff  = {1'b0, bus.data_out} - step_ext;
    up_cross = (up_sum > {1'b0, bus.lim_hi});
    dn_cross = ({1'b0, bus.data_out} < ({1'b0, bus.lim_lo} + step_ext));
    count_ok = bus.count_enb && !bus.cfg_err && (bus.step != '0);
  end

  // Counter state. Priority is reset, then load, then count, then hold.
  // A crossing sets its flag after the clear is applied, so a set on the
  // same edge as clr_flags wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out <= RESET_VAL;
      bus.tc       <= 1'b0;
      bus.ovf      <= 1'b0;
      bus.udf      <= 1'b0;
    end else begin
      bus.tc <= 1'b0;
      if (bus.clr_flags) begin
        bus.ovf <= 1'b0;
        bus.udf <= 1'b0;
      end
      if (!bus.ld_cnt_) begin
        bus.data_out <= bus.data_in;
      end else if (count_ok) begin
        if (bus.updn_cnt) begin
          if (up_cross) begin
            bus.data_out <= bus.sat_mode ? bus.lim_hi : bus.lim_lo;
            bus.tc       <= 1'b1;
            bus.ovf      <= 1'b1;
          end else begin
            bus.data_out <= up_sum[WIDTH-1:0];
          end
        end else begin
          if (dn_cross) begin
            bus.data_out <= bus.sat_mode ? bus.lim_lo : bus.lim_hi;
            bus.tc       <= 1'b1;
            bus.udf      <= 1'b1;
          end else begin
            bus.data_out <= dn_diff[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updn_counter_param.sv
// Self-checking bench for updn_counter_param.
// Each row drives one edge of stimulus and pushes its expected outcome to a
// scoreboard. The outcome is popped and compared once the edge has passed.
module tb_updn_counter_param;
  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  updn_counter_param_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  updn_counter_param #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RESET_VAL(8'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit rst, ld_n, en, up, sat, clr;
    int stp, lo, hi, din;
    int e_data, e_tc, e_ovf, e_udf;
  } row_t;

  typedef logic [WIDTH+2:0] obs_t;   // {data_out, tc, ovf, udf}

  obs_t exp_q[$];
  row_t rows[$];

  function automatic row_t mk(bit r, bit ld_n, bit en, bit up, bit sat, bit clr,
                              int stp, int lo, int hi, int din,
                              int e_data, int e_tc, int e_ovf, int e_udf);
    row_t x;
    x.rst = r; x.ld_n = ld_n; x.en = en; x.up = up; x.sat = sat; x.clr = clr;
    x.stp = stp; x.lo = lo; x.hi = hi; x.din = din;
    x.e_data = e_data; x.e_tc = e_tc; x.e_ovf = e_ovf; x.e_udf = e_udf;
    return x;
  endfunction

  // Drive one row's stimulus on the falling edge and record its expected result.
  task automatic drive(input row_t r);
    @(negedge clk);
    rst           = r.rst;
    bus.ld_cnt_   = r.ld_n;
    bus.count_enb = r.en;
    bus.updn_cnt  = r.up;
    bus.sat_mode  = r.sat;
    bus.clr_flags = r.clr;
    bus.step      = STEP_W'(r.stp);
    bus.lim_lo    = WIDTH'(r.lo);
    bus.lim_hi    = WIDTH'(r.hi);
    bus.data_in   = WIDTH'(r.din);
    exp_q.push_back({WIDTH'(r.e_data), r.e_tc[0], r.e_ovf[0], r.e_udf[0]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    rows.delete();
    rows.push_back(mk(1,0,1,1,0,0, 1,0,255,8'h77, 0,0,0,0));   // rst beats load and count
    rows.push_back(mk(0,0,0,1,0,0, 1,0,255,8'h5A, 8'h5A,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {bus.data_out, bus.tc, bus.ovf, bus.udf};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset row %0d: got %h, expected %h", i, got, want);
      end
    end
    n_tests++;
    if (bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset cfg_err: got %b, expected 0", bus.cfg_err);
    end
  endtask

  task automatic test_wrap_up();
    obs_t got, want;
    rows.delete();
    rows.push_back(mk(0,0,0,1,0,0, 3,10,20,18, 18,0,0,0));
    rows.push_back(mk(0,1,1,1,0,0, 3,10,20,0,  10,1,1,0));
    rows.push_back(mk(0,1,1,1,0,0, 3,10,20,0,  13,0,1,0));
    rows.push_back(mk(0,1,0,1,0,0, 3,10,20,0,  13,0,1,0));   // ovf is sticky
    rows.push_back(mk(0,1,0,1,0,1, 3,10,20,0,  13,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {bus.data_out, bus.tc, bus.ovf, bus.udf};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL wrap_up row %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_sat_down();
    obs_t got, want;
    rows.delete();
    rows.push_back(mk(0,0,0,0,1,0, 4,10,20,12, 12,0,0,0));
    rows.push_back(mk(0,1,1,0,1,0, 4,10,20,0,  10,1,0,1));
    rows.push_back(mk(0,1,1,0,1,0, 4,10,20,0,  10,1,0,1));   // still a crossing
    rows.push_back(mk(0,1,1,0,1,1, 4,10,20,0,  10,1,0,1));   // set beats clear
    rows.push_back(mk(0,1,0,0,1,1, 4,10,20,0,  10,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {bus.data_out, bus.tc, bus.ovf, bus.udf};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL sat_down row %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_hold();
    obs_t got, want;
    rows.delete();
    rows.push_back(mk(0,0,0,1,0,0, 2,10,20,15, 15,0,0,0));
    for (int k = 0; k < 5; k++)
      rows.push_back(mk(0,1,0,1,0,0, 2,10,20,0, 15,0,0,0));
    rows.push_back(mk(0,1,1,1,0,0, 0,10,20,0, 15,0,0,0));    // step 0
    rows.push_back(mk(0,1,1,1,0,0, 2,30,20,0, 15,0,0,0));    // cfg_err
    rows.push_back(mk(0,1,1,0,0,0, 9,30,20,0, 15,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {bus.data_out, bus.tc, bus.ovf, bus.udf};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL hold row %0d: got %h, expected %h", i, got, want);
      end
    end
    n_tests++;
    if (bus.cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_set: got %b, expected 1", bus.cfg_err);
    end
    bus.lim_lo = 8'd20;
    #1;
    n_tests++;
    if (bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_equal_limits: got %b, expected 0", bus.cfg_err);
    end
  endtask

  task automatic test_full_range();
    obs_t got, want;
    rows.delete();
    rows.push_back(mk(0,0,0,1,0,0, 1,0,255,255, 255,0,0,0));
    rows.push_back(mk(0,1,1,1,0,0, 1,0,255,0,   0,1,1,0));
    rows.push_back(mk(0,1,0,1,0,1, 1,0,255,0,   0,0,0,0));
    rows.push_back(mk(0,0,0,0,1,0, 1,0,255,0,   0,0,0,0));
    rows.push_back(mk(0,1,1,0,1,0, 1,0,255,0,   0,1,0,1));
    rows.push_back(mk(0,0,0,1,1,1, 15,0,255,250, 250,0,0,0));
    rows.push_back(mk(0,1,1,1,1,0, 15,0,255,0,  255,1,1,0)); // no mod-256 alias
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {bus.data_out, bus.tc, bus.ovf, bus.udf};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL full_range row %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    rows.delete();
    rows.push_back(mk(0,1,0,1,0,1, 3,10,20,0,  255,0,0,0));
    rows.push_back(mk(0,0,1,1,0,0, 3,10,20,7,  7,0,0,0));    // load beats count
    rows.push_back(mk(0,1,1,1,0,0, 3,10,20,0,  10,0,0,0));   // up from below lo
    rows.push_back(mk(0,0,0,1,0,0, 3,10,20,25, 25,0,0,0));
    rows.push_back(mk(0,1,1,1,0,0, 3,10,20,0,  10,1,1,0));   // up from above hi
    rows.push_back(mk(0,0,0,0,0,0, 3,10,20,5,  5,0,1,0));
    rows.push_back(mk(0,1,1,0,0,0, 3,10,20,0,  20,1,1,1));   // down from below lo
    rows.push_back(mk(0,1,1,0,0,0, 3,10,20,0,  17,0,1,1));
    rows.push_back(mk(1,1,1,0,0,0, 3,10,20,0,  0,0,0,0));    // reset mid-count
    rows.push_back(mk(0,1,1,1,0,0, 3,0,20,0,   3,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {bus.data_out, bus.tc, bus.ovf, bus.udf};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back row %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  initial begin
    bus.ld_cnt_   = 1'b1;
    bus.count_enb = 1'b0;
    bus.updn_cnt  = 1'b1;
    bus.sat_mode  = 1'b0;
    bus.clr_flags = 1'b0;
    bus.step      = '0;
    bus.lim_lo    = '0;
    bus.lim_hi    = '1;
    bus.data_in   = '0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_hold();
    test_full_range();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updn_counter_param.md
# updn_counter_param

Parametrised up/down counter: the next generation of the team's 8-bit load/enable up/down counter. It adds configurable width, a programmable step, programmable lower/upper limits, and wrap or saturate behaviour at those limits. It also provides a terminal-count event pulse and sticky overflow/underflow flags. The block sits in datapath and timer logic as a drop-in wherever a bounded counter is needed, and it is checked by the team's SVA property modules.

## Interface
- WIDTH, 8, counter/data width in bits (≥2)
- STEP_W, 4, width of step input (1..WIDTH)
- RESET_VAL, 0, value of data_out after reset (WIDTH bits)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ld_cnt_  input  1  active-low load; loads data_in
- count_enb  input  1  count enable
- updn_cnt  input  1  1 = count up, 0 = count down
- sat_mode  input  1  1 = saturate at limits, 0 = wrap to opposite limit
- step  input  STEP_W  increment/decrement amount, unsigned
- lim_lo  input  WIDTH  lower limit, unsigned
- lim_hi  input  WIDTH  upper limit, unsigned
- data_in  input  WIDTH  load value
- clr_flags  input  1  clears ovf/udf
- data_out  output  WIDTH  counter value, registered
- tc  output  1  one-cycle pulse: a limit was crossed on the last count
- ovf  output  1  sticky: up-count crossed lim_hi
- udf  output  1  sticky: down-count crossed lim_lo
- cfg_err  output  1  combinational, lim_lo > lim_hi

## Operation
- Priority at each rising clk edge: rst > load (ld_cnt_==0) > count (count_enb==1) > hold.
- Reset: data_out=RESET_VAL, tc=0, ovf=0, udf=0.
- Load: data_out<=data_in unconditionally, with no clamping to limits. tc<=0. Flags unchanged.
- Hold (ld_cnt_==1, count_enb==0): data_out stable, tc<=0.
- Count is suppressed and treated as hold when cfg_err==1 or step==0. No flags change in that case.
- Arithmetic is done at WIDTH+1 bits, unsigned. There is no silent modulo-2^WIDTH wrap.
- Up count: nxt=data_out+step.
  - If nxt ≤ lim_hi: data_out<=nxt.
  - Else (crossing): data_out<=lim_hi if sat_mode, else lim_lo. tc<=1, ovf<=1.
- Down count: crossing when data_out < lim_lo+step, evaluated at WIDTH+1 bits.
  - No crossing: data_out<=data_out−step.
  - Crossing: data_out<=lim_lo if sat_mode, else lim_hi. tc<=1, udf<=1.
- Saturated and holding at a limit still counts as a crossing on each further count in that direction. tc pulses every such cycle.
- A value outside [lim_lo, lim_hi] after a load is handled by the same rules.
  - Up from above lim_hi: crossing.
  - Down from below lim_lo: crossing.
  - Up from below lim_lo: normal add.
- clr_flags clears ovf/udf at the edge. If clr_flags and a new crossing fall on the same edge, the set wins.
- Limit, step and mode inputs are sampled every edge. Changes take effect on the next count.

## Timing
- Every operation updates data_out with 1-cycle latency: inputs sampled at edge N appear on data_out after edge N.
- tc is registered and aligned with the data_out update that performed the crossing. It is high for exactly that one cycle.
- ovf/udf are registered and assert in the same cycle as the corresponding tc.
- cfg_err is purely combinational from lim_lo/lim_hi, with zero latency.
- Reset asserted mid-count takes effect at the next edge and overrides any load or count.
- On the first edge after rst deasserts, normal priority applies.
- No output is X after the first reset edge.

## Test plan
- Reset/load: rst=1 one edge → data_out=0, flags 0. Then ld_cnt_=0, data_in=8'h5A → data_out=8'h5A next cycle, tc=0.
- Wrap up: lim_lo=10, lim_hi=20, step=3, sat_mode=0, load 18, count up → 10 (tc=1, ovf=1), then 13 (tc=0). ovf stays 1 until clr_flags.
- Saturate down: lim_lo=10, lim_hi=20, step=4, sat_mode=1, load 12, count down → 10 (tc=1, udf=1). Another down → 10 with tc=1 again.
- Hold/degenerate: count_enb=0 for 5 cycles → data_out stable. step=0 with count_enb=1 → stable, no tc. lim_lo=30, lim_hi=20 → cfg_err=1, count ignored.
- Full range, WIDTH=8: lim_lo=0, lim_hi=255, step=1, load 255, count up with sat_mode=0 → 0, tc=1. Load 0, count down with sat_mode=1 → 0, udf=1.
- Simultaneous events:
  - rst=1 with ld_cnt_=0 → RESET_VAL.
  - ld_cnt_=0 with count_enb=1 → load wins.
  - clr_flags=1 on a crossing edge → flag ends 1.
